// File: rtl/maze_path_replayer_pkg.sv
// Shared definitions for the maze solver and its path replayer: move
// encoding, replayer state encoding and default geometry.
package maze_path_replayer_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;  // y - 1
  localparam logic [1:0] DIR_RIGHT = 2'b01;  // x + 1
  localparam logic [1:0] DIR_LEFT  = 2'b10;  // x - 1
  localparam logic [1:0] DIR_DOWN  = 2'b11;  // y + 1

  localparam int DEF_COORD_W = 4;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_PTR_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } rp_state_e;

endpackage

// File: rtl/path_lifo_mem.sv
// Move storage for the path replayer: DEPTH x 2-bit register array with a
// synchronous write port and a combinational indexed read port.
module path_lifo_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the owner's count decides which entries
  // are meaningful, so clearing storage is just zeroing that count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maze_path_replayer.sv
// Replays the solver's stored path (pushed goal-to-start) as a start-to-goal
// valid/ready move stream with the running coordinate before each move.
module maze_path_replayer
  import maze_path_replayer_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int COORD_W = DEF_COORD_W,
  parameter int PTR_W   = DEF_PTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [1:0]         wr_dir,
  input  logic               run,
  input  logic               move_ready,
  output logic               move_valid,
  output logic [1:0]         move_dir,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               finished_reading,
  output logic               busy,
  output logic [PTR_W-1:0]   count,
  output logic               overflow,
  output logic               bound_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rp_state_e          state_q;
  logic [PTR_W-1:0]   count_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [COORD_W-1:0] x_d;
  logic [COORD_W-1:0] y_d;
  logic               wrap_d;
  logic               move_valid_q;
  logic               finished_q;
  logic               busy_q;
  logic               overflow_q;
  logic               bound_err_q;
  logic [1:0]         rd_dir;
  logic               can_store;
  logic               push_ok;

  assign can_store = (count_q < PTR_W'(DEPTH));
  assign push_ok   = wr_en && !rst && !clear && (state_q == ST_IDLE) && can_store;

  path_lifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (count_q[AW-1:0]),
    .wdata (wr_dir),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_dir)
  );

  // Position after the move currently offered; wrap flags a step off the grid.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    case (rd_dir)
      DIR_UP: begin
        y_d    = y_q - COORD_W'(1);
        wrap_d = (y_q == '0);
      end
      DIR_RIGHT: begin
        x_d    = x_q + COORD_W'(1);
        wrap_d = &x_q;
      end
      DIR_LEFT: begin
        x_d    = x_q - COORD_W'(1);
        wrap_d = (x_q == '0);
      end
      DIR_DOWN: begin
        y_d    = y_q + COORD_W'(1);
        wrap_d = &y_q;
      end
      default: begin
        x_d    = x_q;
        y_d    = y_q;
        wrap_d = 1'b0;
      end
    endcase
  end

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      move_valid_q <= 1'b0;
      finished_q   <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      bound_err_q  <= 1'b0;
    end else if (clear) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      move_valid_q <= 1'b0;
      finished_q   <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      bound_err_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        if (push_ok) begin
          count_q <= count_q + PTR_W'(1);
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Top of the LIFO holds the move leaving the start cell.
          rd_ptr_q    <= count_q - PTR_W'(1);
          x_q         <= '0;
          y_q         <= '0;
          bound_err_q <= 1'b0;
          if (count_q == '0) begin
            state_q    <= ST_DONE;
            finished_q <= 1'b1;
          end else begin
            state_q      <= ST_EMIT;
            move_valid_q <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (move_ready) begin
            x_q <= x_d;
            y_q <= y_d;
            if (wrap_d) begin
              bound_err_q <= 1'b1;
            end
            if (rd_ptr_q == '0) begin
              state_q      <= ST_DONE;
              move_valid_q <= 1'b0;
              finished_q   <= 1'b1;
            end else begin
              rd_ptr_q <= rd_ptr_q - PTR_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          finished_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_valid       = move_valid_q;
  assign move_dir         = move_valid_q ? rd_dir : 2'b00;
  assign x                = x_q;
  assign y                = y_q;
  assign finished_reading = finished_q;
  assign busy             = busy_q;
  assign count            = count_q;
  assign overflow         = overflow_q;
  assign bound_err        = bound_err_q;

endmodule
